// File: rtl/xtop_pkg.sv
// xtop_pkg: shared constants for the keypad calculator.
//   - datapath / register-file geometry
//   - register-file entry indices
//   - PS/2 numeric-keypad scancodes
//   - keypad digit decode and hex -> 7-segment (active-low) helpers
package xtop_pkg;

  localparam int DATA_W      = 32;
  localparam int REGF_ADDR_W = 4;
  localparam int REGF_DEPTH  = 1 << REGF_ADDR_W;

  // Register-file map
  localparam logic [REGF_ADDR_W-1:0] RF_ACC   = REGF_ADDR_W'(0);
  localparam logic [REGF_ADDR_W-1:0] RF_OPND  = REGF_ADDR_W'(1);
  localparam logic [REGF_ADDR_W-1:0] RF_OP    = REGF_ADDR_W'(2);
  localparam logic [REGF_ADDR_W-1:0] RF_LAST  = REGF_ADDR_W'(3);
  localparam logic [REGF_ADDR_W-1:0] RF_COUNT = REGF_ADDR_W'(4);
  localparam logic [REGF_ADDR_W-1:0] RF_ENTRY = REGF_ADDR_W'(5);
  localparam logic [REGF_ADDR_W-1:0] RF_BRK   = REGF_ADDR_W'(6);

  // Scancodes
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_PLUS  = 8'h79;
  localparam logic [7:0] SC_MINUS = 8'h7B;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_KP0   = 8'h70;
  localparam logic [7:0] SC_KP1   = 8'h69;
  localparam logic [7:0] SC_KP2   = 8'h72;
  localparam logic [7:0] SC_KP3   = 8'h7A;
  localparam logic [7:0] SC_KP4   = 8'h6B;
  localparam logic [7:0] SC_KP5   = 8'h73;
  localparam logic [7:0] SC_KP6   = 8'h74;
  localparam logic [7:0] SC_KP7   = 8'h6C;
  localparam logic [7:0] SC_KP8   = 8'h75;
  localparam logic [7:0] SC_KP9   = 8'h7D;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] val;
  } digit_t;

  function automatic digit_t decode_digit(input logic [7:0] code);
    digit_t d;
    d.hit = 1'b1;
    d.val = 4'd0;
    case (code)
      SC_KP0:  d.val = 4'd0;
      SC_KP1:  d.val = 4'd1;
      SC_KP2:  d.val = 4'd2;
      SC_KP3:  d.val = 4'd3;
      SC_KP4:  d.val = 4'd4;
      SC_KP5:  d.val = 4'd5;
      SC_KP6:  d.val = 4'd6;
      SC_KP7:  d.val = 4'd7;
      SC_KP8:  d.val = 4'd8;
      SC_KP9:  d.val = 4'd9;
      default: d.hit = 1'b0;
    endcase
    return d;
  endfunction

  // {dp,g,f,e,d,c,b,a}, active-low, dp always off
  function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
    logic [7:0] s;
    case (h)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver.
//   Synchronises the asynchronous PS/2 clock/data, detects falling edges of the
//   PS/2 clock and assembles {start, d0..d7, parity, stop} frames. Parity is not
//   checked; a frame with a bad stop bit is dropped.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   i_ps2_clk    PS/2 clock (async)
//   i_ps2_data   PS/2 data (async)
//   o_valid      1-clk pulse when o_byte holds a newly received byte
//   o_byte       received data byte
//
// state   | meaning
// IDLE    | waiting for a start bit (0); a 1 here is line noise and ignored
// DATA    | shifting 8 data bits, LSB first
// PARITY  | parity bit slot, value ignored
// STOP    | stop bit slot; accept byte only if stop bit is 1
module ps2_rx
  import xtop_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_valid,
  output logic [7:0] o_byte
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic [1:0] r_clk_sync;
  logic [1:0] r_dat_sync;
  logic       r_clk_prev;
  logic [1:0] r_state;
  logic [2:0] r_bits_left;
  logic [7:0] r_shift;
  logic       r_valid;
  logic [7:0] r_byte;
  logic       w_fall;
  logic       w_bit;

  assign w_fall  = r_clk_prev & ~r_clk_sync[1];
  assign w_bit   = r_dat_sync[1];
  assign o_valid = r_valid;
  assign o_byte  = r_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      // idle PS/2 lines float high, so reset to 1 to avoid a false edge
      r_clk_sync  <= 2'b11;
      r_dat_sync  <= 2'b11;
      r_clk_prev  <= 1'b1;
      r_state     <= ST_IDLE;
      r_bits_left <= 3'd0;
      r_shift     <= 8'h00;
      r_valid     <= 1'b0;
      r_byte      <= 8'h00;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
      r_clk_prev <= r_clk_sync[1];
      r_valid    <= 1'b0;
      if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            if (!w_bit) begin
              r_state     <= ST_DATA;
              r_bits_left <= 3'd7;
            end
          end
          ST_DATA: begin
            r_shift <= {w_bit, r_shift[7:1]};
            if (r_bits_left == 3'd0) begin
              r_state <= ST_PARITY;
            end else begin
              r_bits_left <= r_bits_left - 3'd1;
            end
          end
          ST_PARITY: r_state <= ST_STOP;
          default: begin
            if (w_bit) begin
              r_valid <= 1'b1;
              r_byte  <= r_shift;
            end
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/xtop_calc.sv
// xtop_calc: keypad calculator top.
//   Receives PS/2 keypad scancodes, builds a decimal operand, applies +/- to an
//   accumulator on Enter and drives a 4-digit multiplexed 7-segment display.
//   All calculator state is held in the register file regf.reg_1.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   ps2_data    PS/2 data (async)
//   ps2_clk     PS/2 clock (async)
//   push_AC     all-clear button, active-high
//   push_C      clear-entry button, active-high
//   disp_ctrl   [11:8] digit anodes (active-low), [7:0] segments {dp,g..a} (active-low)
//   gpo_out     last accepted make-code byte
//
// Decoder state (held in reg_1[RF_BRK][0]):
// state    | meaning
// IDLE     | normal decoding of incoming bytes
// BREAK    | F0 seen; the next byte is a key release and is dropped
module xtop_calc
  import xtop_pkg::*;
#(
  parameter int REFRESH_DIV = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_data,
  input  logic        ps2_clk,
  input  logic        push_AC,
  input  logic        push_C,
  output logic [11:0] disp_ctrl,
  output logic [7:0]  gpo_out
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BREAK = 1'b1;

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(REFRESH_DIV - 1);

  logic              w_rx_valid;
  logic [7:0]        w_rx_byte;
  logic [DATA_W-1:0] w_rf  [REGF_DEPTH];
  logic [DATA_W-1:0] w_nxt [REGF_DEPTH];
  logic              w_btn_ac;
  logic              w_btn_c;
  digit_t            w_dig;
  logic [DATA_W-1:0] w_acc;
  logic [DATA_W-1:0] w_opnd;
  logic              w_op;
  logic              w_entry;
  logic              w_brk;
  logic [15:0]       w_show;
  logic [3:0]        w_nib;

  logic [DIV_W-1:0]  r_div;
  logic [1:0]        r_slot;
  logic [11:0]       r_disp;

  ps2_rx u_ps2_rx (
    .clk       (clk),
    .rst       (rst),
    .i_ps2_clk (ps2_clk),
    .i_ps2_data(ps2_data),
    .o_valid   (w_rx_valid),
    .o_byte    (w_rx_byte)
  );

  // Case-equality makes an undriven (X/Z) button read as released in simulation.
  assign w_btn_ac = (push_AC === 1'b1);
  assign w_btn_c  = (push_C === 1'b1);

  assign w_acc   = w_rf[RF_ACC];
  assign w_opnd  = w_rf[RF_OPND];
  assign w_op    = w_rf[RF_OP][0];
  assign w_entry = w_rf[RF_ENTRY][0];
  assign w_brk   = w_rf[RF_BRK][0];
  assign gpo_out = w_rf[RF_LAST][7:0];
  assign w_dig   = decode_digit(w_rx_byte);

  always_comb begin
    w_nxt = w_rf;
    if (w_rx_valid) begin
      if (w_brk == ST_BREAK) begin
        w_nxt[RF_BRK] = DATA_W'(ST_IDLE);
      end else if (w_rx_byte == SC_BREAK) begin
        w_nxt[RF_BRK] = DATA_W'(ST_BREAK);
      end else if (w_rx_byte != SC_EXT) begin
        w_nxt[RF_LAST]  = DATA_W'(w_rx_byte);
        w_nxt[RF_COUNT] = w_rf[RF_COUNT] + DATA_W'(1);
        if (w_dig.hit) begin
          w_nxt[RF_OPND]  = w_opnd * DATA_W'(10) + DATA_W'(w_dig.val);
          w_nxt[RF_ENTRY] = DATA_W'(1);
        end else begin
          case (w_rx_byte)
            SC_PLUS: begin
              w_nxt[RF_OP]    = DATA_W'(OP_ADD);
              w_nxt[RF_OPND]  = '0;
              w_nxt[RF_ENTRY] = DATA_W'(1);
            end
            SC_MINUS: begin
              w_nxt[RF_OP]    = DATA_W'(OP_SUB);
              w_nxt[RF_OPND]  = '0;
              w_nxt[RF_ENTRY] = DATA_W'(1);
            end
            SC_ENTER: begin
              w_nxt[RF_ACC]   = (w_op == OP_SUB) ? (w_acc - w_opnd) : (w_acc + w_opnd);
              w_nxt[RF_OPND]  = '0;
              w_nxt[RF_ENTRY] = '0;
            end
            default: ;
          endcase
        end
      end
    end
    // buttons are evaluated last so they win over a key landing in the same cycle
    if (w_btn_ac) begin
      w_nxt[RF_ACC]   = '0;
      w_nxt[RF_OPND]  = '0;
      w_nxt[RF_OP]    = '0;
      w_nxt[RF_ENTRY] = '0;
    end else if (w_btn_c) begin
      w_nxt[RF_OPND] = '0;
    end
  end

  if (REGF_DEPTH > 0) begin : regf
    logic [DATA_W-1:0] reg_1 [REGF_DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        reg_1 <= '{default: '0};
      end else begin
        reg_1 <= w_nxt;
      end
    end

    assign w_rf = reg_1;
  end

  assign w_show = w_entry ? w_opnd[15:0] : w_acc[15:0];
  assign w_nib  = w_show[{r_slot, 2'b00} +: 4];

  // Slot timer reloads to REFRESH_DIV-1 and advances the slot on terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= DIV_LOAD;
      r_slot <= 2'd0;
      r_disp <= 12'hEC0;
    end else begin
      if (r_div == '0) begin
        r_div  <= DIV_LOAD;
        r_slot <= r_slot + 2'd1;
      end else begin
        r_div <= r_div - DIV_W'(1);
      end
      r_disp <= {~(4'b0001 << r_slot), hex_to_seg(w_nib)};
    end
  end

  assign disp_ctrl = r_disp;

endmodule

// File: tb/tb_xtop_calc.sv
module tb_xtop_calc;

  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_data = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        push_AC = 1'b0;
  logic        push_C = 1'b0;
  logic [11:0] disp_ctrl;
  logic [7:0]  gpo_out;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int unsigned m_acc, m_opnd, m_op, m_entry, m_last, m_cnt;
  bit          m_brk;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] dig_codes [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
  logic [7:0] pool [18] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75,
                            8'h7D, 8'h79, 8'h7B, 8'h5A, 8'h5A, 8'hF0, 8'hE0, 8'h1C, 8'h76};

  logic [31:0] d_acc, d_opnd, d_op, d_last, d_cnt, d_entry;
  assign d_acc   = dut.regf.reg_1[0];
  assign d_opnd  = dut.regf.reg_1[1];
  assign d_op    = dut.regf.reg_1[2];
  assign d_last  = dut.regf.reg_1[3];
  assign d_cnt   = dut.regf.reg_1[4];
  assign d_entry = dut.regf.reg_1[5];

  xtop_calc #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_data (ps2_data),
    .ps2_clk  (ps2_clk),
    .push_AC  (push_AC),
    .push_C   (push_C),
    .disp_ctrl(disp_ctrl),
    .gpo_out  (gpo_out)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int digit_of(input logic [7:0] b);
    for (int i = 0; i < 10; i++) if (dig_codes[i] == b) return i;
    return -1;
  endfunction

  function automatic logic [3:0] next_anode(input logic [3:0] a);
    case (a)
      4'hE: return 4'hD;
      4'hD: return 4'hB;
      4'hB: return 4'h7;
      default: return 4'hE;
    endcase
  endfunction

  task automatic model_key(input logic [7:0] b);
    int d;
    if (m_brk) begin
      m_brk = 0;
      return;
    end
    if (b == 8'hF0) begin
      m_brk = 1;
      return;
    end
    if (b == 8'hE0) return;
    m_last = b;
    m_cnt  = m_cnt + 1;
    d = digit_of(b);
    if (d >= 0) begin
      m_opnd  = m_opnd * 10 + d;
      m_entry = 1;
    end else if (b == 8'h79) begin
      m_op = 0; m_opnd = 0; m_entry = 1;
    end else if (b == 8'h7B) begin
      m_op = 1; m_opnd = 0; m_entry = 1;
    end else if (b == 8'h5A) begin
      m_acc   = (m_op != 0) ? m_acc - m_opnd : m_acc + m_opnd;
      m_opnd  = 0;
      m_entry = 0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [10:0] bits;
    bits = {stop_bit, ~^b, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1 ps2_data = bits[i];
      repeat (8) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (8) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    repeat (8) @(posedge clk);
    #1 ps2_data = 1'b1;
  endtask

  task automatic send_key(input logic [7:0] b);
    send_frame(b, 1'b1);
    model_key(b);
  endtask

  task automatic pulse_button(input bit is_ac);
    @(posedge clk);
    #1 if (is_ac) push_AC = 1'b1; else push_C = 1'b1;
    @(posedge clk);
    #1 begin push_AC = 1'b0; push_C = 1'b0; end
    if (is_ac) begin
      m_acc = 0; m_opnd = 0; m_op = 0; m_entry = 0;
    end else begin
      m_opnd = 0;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_display(input logic [15:0] val, input string name);
    bit   seen [4];
    int   bad = 0;
    int   slot;
    for (int c = 0; c < 4 * DIV + 8; c++) begin
      @(negedge clk);
      case (disp_ctrl[11:8])
        4'hE: slot = 0;
        4'hD: slot = 1;
        4'hB: slot = 2;
        4'h7: slot = 3;
        default: slot = -1;
      endcase
      if (slot < 0) bad++;
      else begin
        seen[slot] = 1'b1;
        if (disp_ctrl[7:0] !== seg_tab[(val >> (4 * slot)) & 16'hF]) bad++;
      end
    end
    n_checks++;
    if (bad != 0 || !(seen[0] && seen[1] && seen[2] && seen[3])) begin
      n_errors++;
      $display("FAIL %s: display wrong in %0d samples, digits seen %b%b%b%b, required value %h",
               name, bad, seen[3], seen[2], seen[1], seen[0], val);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_acc = 0; m_opnd = 0; m_op = 0; m_entry = 0; m_last = 0; m_cnt = 0; m_brk = 0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (dut.regf.reg_1[i] !== 32'h0) begin
        n_errors++;
        $display("FAIL reset_reg%0d: got %h required 0", i, dut.regf.reg_1[i]);
      end
    end
    n_checks++;
    if (gpo_out !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_gpo: got %h required 00", gpo_out);
    end
    n_checks++;
    if (disp_ctrl !== 12'hEC0) begin
      n_errors++;
      $display("FAIL reset_disp: got %h required EC0", disp_ctrl);
    end
  endtask

  task automatic test_sequence();
    send_key(8'h79); send_key(8'h69); send_key(8'h74); send_key(8'h5A);
    n_checks++;
    if (d_acc !== 32'h10) begin n_errors++; $display("FAIL seq1_acc: got %h required 00000010", d_acc); end
    n_checks++;
    if (d_opnd !== 32'h0) begin n_errors++; $display("FAIL seq1_opnd: got %h required 0", d_opnd); end
    n_checks++;
    if (gpo_out !== 8'h5A) begin n_errors++; $display("FAIL seq1_gpo: got %h required 5A", gpo_out); end
    n_checks++;
    if (d_cnt !== 32'd4) begin n_errors++; $display("FAIL seq1_count: got %0d required 4", d_cnt); end
    test_display(16'h0010, "seq1_display");
    send_key(8'h79); send_key(8'h5A);
    n_checks++;
    if (d_acc !== 32'h10) begin n_errors++; $display("FAIL seq2_acc: got %h required 00000010", d_acc); end
    send_key(8'h7B); send_key(8'h75); send_key(8'h7D);
    n_checks++;
    if (d_opnd !== 32'd89 || d_entry !== 32'd1) begin
      n_errors++;
      $display("FAIL seq3_entry: got opnd %0d entry %0d required 89 1", d_opnd, d_entry);
    end
    test_display(16'h0059, "seq3_display");
    send_key(8'h5A);
    n_checks++;
    if (d_acc !== 32'hFFFFFFB7) begin n_errors++; $display("FAIL seq4_acc: got %h required FFFFFFB7", d_acc); end
    test_display(16'hFFB7, "seq4_display");
  endtask

  task automatic test_break();
    send_key(8'hF0); send_key(8'h69);
    n_checks++;
    if (d_acc !== m_acc || d_opnd !== m_opnd) begin
      n_errors++;
      $display("FAIL break_state: got acc %h opnd %h required %h %h", d_acc, d_opnd, m_acc, m_opnd);
    end
    n_checks++;
    if (gpo_out !== 8'h5A) begin n_errors++; $display("FAIL break_gpo: got %h required 5A", gpo_out); end
    send_key(8'h69);
    n_checks++;
    if (d_opnd !== m_opnd || gpo_out !== 8'h69) begin
      n_errors++;
      $display("FAIL break_release: got opnd %0d gpo %h required %0d 69", d_opnd, gpo_out, m_opnd);
    end
  endtask

  task automatic test_bad_stop();
    send_frame(8'h69, 1'b0);
    n_checks++;
    if (d_opnd !== m_opnd || d_cnt !== m_cnt || gpo_out !== m_last[7:0]) begin
      n_errors++;
      $display("FAIL bad_stop: got opnd %0d cnt %0d gpo %h required %0d %0d %h",
               d_opnd, d_cnt, gpo_out, m_opnd, m_cnt, m_last[7:0]);
    end
  endtask

  task automatic test_buttons();
    send_key(8'h69); send_key(8'h72);
    n_checks++;
    if (d_opnd !== m_opnd) begin n_errors++; $display("FAIL btn_digits: got %0d required %0d", d_opnd, m_opnd); end
    pulse_button(1'b0);
    n_checks++;
    if (d_opnd !== 32'h0 || d_acc !== m_acc) begin
      n_errors++;
      $display("FAIL btn_c: got opnd %0d acc %h required 0 %h", d_opnd, d_acc, m_acc);
    end
    pulse_button(1'b1);
    n_checks++;
    if (d_acc !== 32'h0 || d_op !== 32'h0 || d_entry !== 32'h0) begin
      n_errors++;
      $display("FAIL btn_ac: got acc %h op %0d entry %0d required 0 0 0", d_acc, d_op, d_entry);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int k = 0; k < 60; k++) begin
      b = pool[$urandom_range(17, 0)];
      send_key(b);
      if ($urandom_range(9, 0) == 0) pulse_button($urandom_range(1, 0) == 1);
      n_checks++;
      if (d_acc !== m_acc || d_opnd !== m_opnd || d_op !== m_op || d_entry !== m_entry ||
          d_last !== m_last || d_cnt !== m_cnt || gpo_out !== m_last[7:0]) begin
        n_errors++;
        $display("FAIL rand_%0d key %h: got acc %h opnd %h op %0d entry %0d last %h cnt %0d required %h %h %0d %0d %h %0d",
                 k, b, d_acc, d_opnd, d_op, d_entry, d_last, d_cnt,
                 m_acc, m_opnd, m_op, m_entry, m_last, m_cnt);
      end
    end
    test_display((m_entry != 0) ? m_opnd[15:0] : m_acc[15:0], "rand_display");
  endtask

  task automatic test_display_cycle();
    logic [3:0] prev, cur;
    int dwell = 0, trans = 0, bad_order = 0, bad_dwell = 0, bad_hot = 0;
    @(negedge clk);
    prev = disp_ctrl[11:8];
    for (int c = 0; c < 8 * DIV; c++) begin
      @(negedge clk);
      cur = disp_ctrl[11:8];
      dwell++;
      if ($countones(~cur) != 1) bad_hot++;
      if (cur != prev) begin
        if (cur != next_anode(prev)) bad_order++;
        if (trans > 0 && dwell != DIV) bad_dwell++;
        trans++;
        dwell = 0;
      end
      prev = cur;
    end
    n_checks++;
    if (bad_hot != 0) begin n_errors++; $display("FAIL anode_onehot: %0d bad samples required 0", bad_hot); end
    n_checks++;
    if (bad_order != 0) begin n_errors++; $display("FAIL anode_order: %0d bad steps required 0", bad_order); end
    n_checks++;
    if (bad_dwell != 0) begin n_errors++; $display("FAIL anode_dwell: %0d bad dwells required 0", bad_dwell); end
    n_checks++;
    if (trans < 7) begin n_errors++; $display("FAIL anode_steps: got %0d transitions required at least 7", trans); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_break();
    test_bad_stop();
    test_buttons();
    test_random();
    test_display_cycle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
